// File: rtl/image_capture_sequencer.sv
// Burst sequencer: times exposure per selected camera, fires the
// capture engine, then waits for done or timeout before moving on.
module image_capture_sequencer #(
  parameter int EXP_UNIT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES  = 5000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture_trigger,
  input  logic       reduce_resolution,
  input  logic [1:0] cam_sel_bitmask,
  input  logic [1:0] exposure_level,
  input  logic       cap_done,
  output logic       exp_en,
  output logic       cap_start,
  output logic       cap_cam_id,
  output logic       cap_reduce,
  output logic       busy,
  output logic       seq_done,
  output logic [1:0] cam_fault,
  output logic       trig_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    EXPOSE,
    START,
    WAIT_DONE,
    NEXT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] EXP_UNIT = CNT_W'(EXP_UNIT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mask_q;
  logic [1:0]       lvl_q;
  logic [CNT_W-1:0] exp_last;

  // Last count of the exposure window for the latched level
  always_comb begin
    exp_last = EXP_UNIT * ({{(CNT_W-2){1'b0}}, lvl_q} + CNT_W'(1))
             - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mask_q       <= '0;
      lvl_q        <= '0;
      exp_en       <= 1'b0;
      cap_start    <= 1'b0;
      cap_cam_id   <= 1'b0;
      cap_reduce   <= 1'b0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      cam_fault    <= '0;
      trig_overrun <= 1'b0;
    end else begin
      cap_start <= 1'b0;
      seq_done  <= 1'b0;
      if (capture_trigger && state != IDLE)
        trig_overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (capture_trigger) begin
            mask_q       <= cam_sel_bitmask;
            lvl_q        <= exposure_level;
            cap_reduce   <= reduce_resolution;
            cam_fault    <= '0;
            trig_overrun <= 1'b0;
            busy         <= 1'b1;
            cnt          <= '0;
            if (cam_sel_bitmask != 2'b00) begin
              state      <= EXPOSE;
              exp_en     <= 1'b1;
              cap_cam_id <= ~cam_sel_bitmask[0];
            end else begin
              state      <= DONE;
              seq_done   <= 1'b1;
              cap_cam_id <= 1'b0;
            end
          end
        end
        EXPOSE: begin
          if (cnt == exp_last) begin
            exp_en    <= 1'b0;
            cap_start <= 1'b1;
            state     <= START;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done arriving in the expiry cycle still wins
          if (cap_done) begin
            state <= NEXT;
          end else if (cnt == TO_LAST) begin
            cam_fault[cap_cam_id] <= 1'b1;
            state                 <= NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        NEXT: begin
          if (!cap_cam_id && mask_q[1]) begin
            cap_cam_id <= 1'b1;
            cnt        <= '0;
            exp_en     <= 1'b1;
            state      <= EXPOSE;
          end else begin
            seq_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_capture_sequencer.sv
// Bench for image_capture_sequencer: directed scenarios plus random
// bursts checked against an arithmetic burst-timing model.
module tb_image_capture_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic       reduce;
  logic [1:0] mask;
  logic [1:0] lvl;
  logic       cap_done;
  logic       exp_en;
  logic       cap_start;
  logic       cap_cam_id;
  logic       cap_reduce;
  logic       busy;
  logic       seq_done;
  logic [1:0] cam_fault;
  logic       trig_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_seq_cyc;
  int         obs_starts;
  int         obs_ids [0:3];
  int         obs_exp [0:1];
  int         obs_red_bad;
  int         obs_busy_bad;
  int         obs_overlap;
  logic       obs_after_busy;
  logic       obs_after_seq;
  logic [1:0] obs_fault;
  logic       obs_ovr;
  logic [1:0] obs_fault_c1;
  logic       obs_ovr_c1;

  always #5 clk = ~clk;

  image_capture_sequencer #(
    .EXP_UNIT_CYCLES(4),
    .TIMEOUT_CYCLES (50),
    .CNT_W          (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .capture_trigger  (trig),
    .reduce_resolution(reduce),
    .cam_sel_bitmask  (mask),
    .exposure_level   (lvl),
    .cap_done         (cap_done),
    .exp_en           (exp_en),
    .cap_start        (cap_start),
    .cap_cam_id       (cap_cam_id),
    .cap_reduce       (cap_reduce),
    .busy             (busy),
    .seq_done         (seq_done),
    .cam_fault        (cam_fault),
    .trig_overrun     (trig_overrun)
  );

  function automatic int e_len(logic [1:0] l);
    return 4 * (int'(l) + 1);
  endfunction

  function automatic bit ok_d(int d);
    return d >= 1 && d <= 50;
  endfunction

  function automatic int w_len(int d);
    return ok_d(d) ? d : 50;
  endfunction

  function automatic int m_seq(logic [1:0] m, logic [1:0] l,
                               int d0, int d1);
    int t;
    t = 1;
    if (m[0]) t += e_len(l) + 2 + w_len(d0);
    if (m[1]) t += e_len(l) + 2 + w_len(d1);
    return t;
  endfunction

  function automatic logic [1:0] m_fault(logic [1:0] m, int d0, int d1);
    return {m[1] && !ok_d(d1), m[0] && !ok_d(d0)};
  endfunction

  function automatic int m_starts(logic [1:0] m);
    return int'(m[0]) + int'(m[1]);
  endfunction

  // Drives one burst and acts as the capture engine; d0/d1 are the
  // cap_done delays after cap_start for cam1/cam2 (0 = never answer).
  task automatic run_burst(input logic [1:0] m, input logic [1:0] l,
                           input logic r, input int d0, input int d1,
                           input bit retrig, input bit stray,
                           input bit tad);
    int k;
    int pend;
    int dd;
    bit seen;
    obs_seq_cyc  = -1;
    obs_starts   = 0;
    obs_ids      = '{-1, -1, -1, -1};
    obs_exp      = '{0, 0};
    obs_red_bad  = 0;
    obs_busy_bad = 0;
    obs_overlap  = 0;
    obs_fault_c1 = 2'bxx;
    obs_ovr_c1   = 1'bx;
    @(negedge clk);
    mask = m;
    lvl = l;
    reduce = r;
    trig = 1'b1;
    cap_done = 1'b0;
    pend = -1;
    seen = 0;
    k = 0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      trig = 1'b0;
      cap_done = 1'b0;
      if (k == 1) begin
        obs_fault_c1 = cam_fault;
        obs_ovr_c1 = trig_overrun;
      end
      if (!busy) obs_busy_bad++;
      if (exp_en) obs_exp[cap_cam_id]++;
      if (exp_en && cap_start) obs_overlap++;
      if (cap_start) begin
        if (obs_starts < 4) obs_ids[obs_starts] = int'(cap_cam_id);
        obs_starts++;
        if (cap_reduce !== r) obs_red_bad++;
        dd = cap_cam_id ? d1 : d0;
        if (dd > 0) pend = k + dd;
      end
      if (k == pend) cap_done = 1'b1;
      if (stray && k == 2) cap_done = 1'b1;
      if (retrig && k == 3) begin
        trig = 1'b1;
        mask = 2'($urandom);
        lvl = 2'($urandom);
        reduce = 1'($urandom);
      end
      if (seq_done) begin
        seen = 1;
        obs_seq_cyc = k;
        if (tad) trig = 1'b1;
      end
    end
    @(negedge clk);
    trig = 1'b0;
    cap_done = 1'b0;
    obs_after_busy = busy;
    obs_after_seq = seq_done;
    obs_fault = cam_fault;
    obs_ovr = trig_overrun;
  endtask

  task automatic test_reset;
    logic [8:0] o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    o = {exp_en, cap_start, cap_cam_id, cap_reduce, busy, seq_done,
         cam_fault, trig_overrun};
    n_cmp++;
    if (o !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outs got %b want 0", o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cap_start, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_after got %b want 00", {cap_start, busy});
    end
  endtask

  task automatic test_single;
    run_burst(2'b01, 2'd0, 1'b1, 3, 0, 0, 0, 0);
    n_cmp++;
    if (obs_exp[0] != 4 || obs_exp[1] != 0) begin
      n_bad++;
      $display("FAIL single_exp got %0d/%0d want 4/0",
               obs_exp[0], obs_exp[1]);
    end
    n_cmp++;
    if (obs_starts != 1 || obs_ids[0] != 0 || obs_red_bad != 0) begin
      n_bad++;
      $display("FAIL single_start got n=%0d id=%0d redbad=%0d want 1/0/0",
               obs_starts, obs_ids[0], obs_red_bad);
    end
    n_cmp++;
    if (obs_seq_cyc != 10 || obs_fault !== 2'b00) begin
      n_bad++;
      $display("FAIL single_done got cyc=%0d fault=%b want 10/00",
               obs_seq_cyc, obs_fault);
    end
  endtask

  task automatic test_dual;
    run_burst(2'b11, 2'd3, 1'b0, 2, 5, 0, 0, 0);
    n_cmp++;
    if (obs_exp[0] != 16 || obs_exp[1] != 16) begin
      n_bad++;
      $display("FAIL dual_exp got %0d/%0d want 16/16",
               obs_exp[0], obs_exp[1]);
    end
    n_cmp++;
    if (obs_starts != 2 || obs_ids[0] != 0 || obs_ids[1] != 1) begin
      n_bad++;
      $display("FAIL dual_start got n=%0d ids=%0d,%0d want 2 0,1",
               obs_starts, obs_ids[0], obs_ids[1]);
    end
    n_cmp++;
    if (obs_seq_cyc != 44 || obs_after_seq !== 1'b0) begin
      n_bad++;
      $display("FAIL dual_done got cyc=%0d after=%b want 44/0",
               obs_seq_cyc, obs_after_seq);
    end
  endtask

  task automatic test_timeout;
    run_burst(2'b10, 2'd0, 1'b0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs_starts != 1 || obs_ids[0] != 1) begin
      n_bad++;
      $display("FAIL to_start got n=%0d id=%0d want 1/1",
               obs_starts, obs_ids[0]);
    end
    n_cmp++;
    if (obs_seq_cyc != 57 || obs_fault !== 2'b10) begin
      n_bad++;
      $display("FAIL to_fault got cyc=%0d fault=%b want 57/10",
               obs_seq_cyc, obs_fault);
    end
    run_burst(2'b10, 2'd0, 1'b0, 0, 50, 0, 0, 0);
    n_cmp++;
    if (obs_seq_cyc != 57 || obs_fault !== 2'b00) begin
      n_bad++;
      $display("FAIL to_edge got cyc=%0d fault=%b want 57/00",
               obs_seq_cyc, obs_fault);
    end
    n_cmp++;
    if (obs_fault_c1 !== 2'b00) begin
      n_bad++;
      $display("FAIL to_clear got %b want 00", obs_fault_c1);
    end
  endtask

  task automatic test_overrun;
    run_burst(2'b11, 2'd1, 1'b1, 4, 4, 1, 1, 0);
    n_cmp++;
    if (obs_seq_cyc != m_seq(2'b11, 2'd1, 4, 4) || obs_starts != 2) begin
      n_bad++;
      $display("FAIL ovr_burst got cyc=%0d n=%0d want %0d/2",
               obs_seq_cyc, obs_starts, m_seq(2'b11, 2'd1, 4, 4));
    end
    n_cmp++;
    if (obs_ovr !== 1'b1 || obs_exp[0] != 8 || obs_exp[1] != 8) begin
      n_bad++;
      $display("FAIL ovr_flag got ovr=%b exp=%0d/%0d want 1 8/8",
               obs_ovr, obs_exp[0], obs_exp[1]);
    end
    run_burst(2'b01, 2'd0, 1'b0, 1, 0, 0, 0, 1);
    n_cmp++;
    if (obs_ovr_c1 !== 1'b0 || obs_ovr !== 1'b1 ||
        obs_after_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_done got c1=%b end=%b busy=%b want 0/1/0",
               obs_ovr_c1, obs_ovr, obs_after_busy);
    end
  endtask

  task automatic test_empty;
    run_burst(2'b00, 2'd2, 1'b1, 1, 1, 0, 0, 0);
    n_cmp++;
    if (obs_seq_cyc != 1 || obs_starts != 0 ||
        obs_exp[0] + obs_exp[1] != 0) begin
      n_bad++;
      $display("FAIL empty got cyc=%0d n=%0d exp=%0d want 1/0/0",
               obs_seq_cyc, obs_starts, obs_exp[0] + obs_exp[1]);
    end
    n_cmp++;
    if (obs_after_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_busy got %b want 0", obs_after_busy);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    logic [8:0] o;
    @(negedge clk);
    mask = 2'b11;
    lvl = 2'd0;
    reduce = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    k = 1;
    while (!cap_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 50) begin
      n_bad++;
      $display("FAIL rmid_start got timeout want cap_start");
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    o = {exp_en, cap_start, cap_cam_id, cap_reduce, busy, seq_done,
         cam_fault, trig_overrun};
    n_cmp++;
    if (o !== 9'd0) begin
      n_bad++;
      $display("FAIL rmid_outs got %b want 0", o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cap_start, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL rmid_after got %b want 00", {cap_start, busy});
    end
    run_burst(2'b01, 2'd1, 1'b0, 2, 0, 0, 0, 0);
    n_cmp++;
    if (obs_seq_cyc != 13 || obs_starts != 1 || obs_exp[0] != 8) begin
      n_bad++;
      $display("FAIL rmid_burst got cyc=%0d n=%0d exp=%0d want 13/1/8",
               obs_seq_cyc, obs_starts, obs_exp[0]);
    end
  endtask

  task automatic test_random;
    logic [1:0] m;
    logic [1:0] l;
    logic       r;
    int         d0;
    int         d1;
    bit         rt;
    bit         st;
    bit         td;
    for (int i = 0; i < 30; i++) begin
      m  = 2'($urandom);
      l  = 2'($urandom);
      r  = 1'($urandom);
      d0 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 55));
      d1 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 55));
      rt = 1'($urandom);
      st = 1'($urandom);
      td = 1'($urandom);
      run_burst(m, l, r, d0, d1, rt, st, td);
      n_cmp++;
      if (obs_seq_cyc != m_seq(m, l, d0, d1)) begin
        n_bad++;
        $display("FAIL rnd%0d_len got %0d want %0d (m=%b l=%0d d=%0d,%0d)",
                 i, obs_seq_cyc, m_seq(m, l, d0, d1), m, l, d0, d1);
      end
      n_cmp++;
      if (obs_starts != m_starts(m) ||
          obs_exp[0] != (m[0] ? e_len(l) : 0) ||
          obs_exp[1] != (m[1] ? e_len(l) : 0)) begin
        n_bad++;
        $display("FAIL rnd%0d_cams got n=%0d exp=%0d/%0d m=%b l=%0d",
                 i, obs_starts, obs_exp[0], obs_exp[1], m, l);
      end
      if (m != 2'b00) begin
        n_cmp++;
        if (obs_ids[0] != (m[0] ? 0 : 1) ||
            (m == 2'b11 && obs_ids[1] != 1)) begin
          n_bad++;
          $display("FAIL rnd%0d_ids got %0d,%0d m=%b",
                   i, obs_ids[0], obs_ids[1], m);
        end
      end
      n_cmp++;
      if (obs_fault !== m_fault(m, d0, d1) ||
          obs_ovr !== ((rt && m != 2'b00) || td)) begin
        n_bad++;
        $display("FAIL rnd%0d_flags got f=%b o=%b want f=%b o=%b",
                 i, obs_fault, obs_ovr, m_fault(m, d0, d1),
                 (rt && m != 2'b00) || td);
      end
      n_cmp++;
      if (obs_fault_c1 !== 2'b00 || obs_ovr_c1 !== 1'b0 ||
          obs_busy_bad != 0 || obs_after_busy !== 1'b0 ||
          obs_red_bad != 0 || obs_overlap != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_misc got c1=%b%b bb=%0d ab=%b rb=%0d ov=%0d",
                 i, obs_fault_c1, obs_ovr_c1, obs_busy_bad,
                 obs_after_busy, obs_red_bad, obs_overlap);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    trig = 1'b0;
    reduce = 1'b0;
    mask = 2'b00;
    lvl = 2'd0;
    cap_done = 1'b0;
    test_reset();
    test_single();
    test_dual();
    test_timeout();
    test_overrun();
    test_empty();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
